// File: rtl/pc_return_stack.sv
// rtl/pc_return_stack.sv - Return-address stack with next-PC source mux
//
// Holds up to DEPTH 10-bit return addresses. PUSH stores PC_COUNT (CALL or
// interrupt entry), POP discards the top entry (RET or RETI). DIN selects the
// next PC: 0=IR_ADDR, 1=TOS, 2=VECTOR, 3=10'h000. DIN is combinational, so a
// RET with PC_MUX_SEL=1 hands the pre-pop top entry to the PC on the same edge
// that pops it.
//
// Ports:
//   CLK, RST         clock (rising edge), asynchronous active-high reset
//   PC_COUNT [9:0]   value written by a push
//   IR_ADDR  [9:0]   branch/call target
//   PC_MUX_SEL [1:0] DIN source select
//   PUSH, POP        stack operations; both together replace the top entry
//   CLR_ERR          clears OVF/UNF (a coincident new error still sets them)
//   DIN [9:0]        next-PC value
//   TOS [9:0]        top entry, 0 when empty
//   COUNT [6:0]      valid entries; FULL / EMPTY decode it
//   OVF, UNF         sticky push-while-full / pop-while-empty flags
//
// Build option: PC_STACK_WRAP_EN makes a push while full overwrite the oldest
// entry (circular buffer with a base pointer) instead of dropping the push.

module pc_return_stack #(
    parameter int         DEPTH  = 16,
    parameter logic [9:0] VECTOR = 10'h3FF
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [9:0] PC_COUNT,
    input  logic [9:0] IR_ADDR,
    input  logic [1:0] PC_MUX_SEL,
    input  logic       PUSH,
    input  logic       POP,
    input  logic       CLR_ERR,
    output logic [9:0] DIN,
    output logic [9:0] TOS,
    output logic [6:0] COUNT,
    output logic       FULL,
    output logic       EMPTY,
    output logic       OVF,
    output logic       UNF
);

    localparam int         AW      = $clog2(DEPTH);
    localparam logic [6:0] DEPTH_C = 7'(DEPTH);

    logic [9:0]    mem_q [DEPTH];
    logic [6:0]    count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          ovf_set, unf_set;
    logic          we;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    logic          empty, full;

`ifdef PC_STACK_WRAP_EN
    logic [AW-1:0] base_q, base_d;

    // Reduce base+offset modulo DEPTH; inputs never exceed 2*DEPTH-1.
    function automatic logic [AW-1:0] ring(input logic [7:0] raw);
        logic [7:0] r;
        r = (raw >= 8'(DEPTH)) ? raw - 8'(DEPTH) : raw;
        return AW'(r);
    endfunction

    assign rd_idx = ring(8'(base_q) + 8'(count_q) - 8'd1);
`else
    assign rd_idx = AW'(count_q - 7'd1);
`endif

    assign empty = (count_q == 7'd0);
    assign full  = (count_q == DEPTH_C);

    always_comb begin
        count_d = count_q;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        we      = 1'b0;
        wr_idx  = rd_idx;
`ifdef PC_STACK_WRAP_EN
        base_d  = base_q;
`endif
        if (PUSH && POP && !empty) begin
            // Replace the top entry; depth is unchanged.
            we     = 1'b1;
            wr_idx = rd_idx;
        end else if (PUSH) begin
            // Also covers PUSH+POP on an empty stack, which acts as a push.
            if (!full) begin
                we      = 1'b1;
`ifdef PC_STACK_WRAP_EN
                wr_idx  = ring(8'(base_q) + 8'(count_q));
`else
                wr_idx  = AW'(count_q);
`endif
                count_d = count_q + 7'd1;
            end else begin
                ovf_set = 1'b1;
`ifdef PC_STACK_WRAP_EN
                // Oldest slot becomes the new top; base moves past it.
                we      = 1'b1;
                wr_idx  = base_q;
                base_d  = ring(8'(base_q) + 8'd1);
`endif
            end
        end else if (POP) begin
            if (!empty) begin
                count_d = count_q - 7'd1;
            end else begin
                unf_set = 1'b1;
            end
        end
        ovf_d = ovf_set | (ovf_q & ~CLR_ERR);
        unf_d = unf_set | (unf_q & ~CLR_ERR);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count_q <= 7'd0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 10'h000;
            end
`ifdef PC_STACK_WRAP_EN
            base_q  <= '0;
`endif
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            if (we) begin
                mem_q[wr_idx] <= PC_COUNT;
            end
`ifdef PC_STACK_WRAP_EN
            base_q  <= base_d;
`endif
        end
    end

    assign TOS = empty ? 10'h000 : mem_q[rd_idx];

    always_comb begin
        case (PC_MUX_SEL)
            2'd0:    DIN = IR_ADDR;
            2'd1:    DIN = TOS;
            2'd2:    DIN = VECTOR;
            default: DIN = 10'h000;
        endcase
    end

    assign COUNT = count_q;
    assign FULL  = full;
    assign EMPTY = empty;
    assign OVF   = ovf_q;
    assign UNF   = unf_q;

endmodule

// File: tb/tb_pc_return_stack.sv
// tb/tb_pc_return_stack.sv - Self-checking bench for pc_return_stack

module tb_pc_return_stack;

    localparam int DEPTH = 16;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [9:0] PC_COUNT = '0;
    logic [9:0] IR_ADDR = '0;
    logic [1:0] PC_MUX_SEL = '0;
    logic       PUSH = 1'b0;
    logic       POP = 1'b0;
    logic       CLR_ERR = 1'b0;
    logic [9:0] DIN, TOS;
    logic [6:0] COUNT;
    logic       FULL, EMPTY, OVF, UNF;

    int total = 0;
    int bad = 0;

    logic [9:0] stk[$];
    bit         m_ovf = 0;
    bit         m_unf = 0;

    pc_return_stack #(.DEPTH(DEPTH), .VECTOR(10'h3FF)) dut (
        .CLK(CLK), .RST(RST), .PC_COUNT(PC_COUNT), .IR_ADDR(IR_ADDR),
        .PC_MUX_SEL(PC_MUX_SEL), .PUSH(PUSH), .POP(POP), .CLR_ERR(CLR_ERR),
        .DIN(DIN), .TOS(TOS), .COUNT(COUNT), .FULL(FULL), .EMPTY(EMPTY),
        .OVF(OVF), .UNF(UNF)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] m_tos();
        return (stk.size() == 0) ? 10'h000 : stk[stk.size()-1];
    endfunction

    function automatic logic [9:0] m_din();
        case (PC_MUX_SEL)
            2'd0:    return IR_ADDR;
            2'd1:    return m_tos();
            2'd2:    return 10'h3FF;
            default: return 10'h000;
        endcase
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".count"}, 32'(COUNT), 32'(stk.size()));
        chk({tag, ".tos"},   32'(TOS),   32'(m_tos()));
        chk({tag, ".full"},  32'(FULL),  32'(stk.size() == DEPTH));
        chk({tag, ".empty"}, 32'(EMPTY), 32'(stk.size() == 0));
        chk({tag, ".ovf"},   32'(OVF),   32'(m_ovf));
        chk({tag, ".unf"},   32'(UNF),   32'(m_unf));
        chk({tag, ".din"},   32'(DIN),   32'(m_din()));
    endtask

    // Called at a negedge: drive, check pre-edge outputs, clock, update model.
    task automatic step(input string tag, input bit push, input bit pop, input bit clr,
                        input logic [1:0] sel, input logic [9:0] pc, input logic [9:0] ir);
        bit ovf_ev, unf_ev;
        PUSH = push; POP = pop; CLR_ERR = clr;
        PC_MUX_SEL = sel; PC_COUNT = pc; IR_ADDR = ir;
        #1;
        check_all(tag);
        @(posedge CLK);
        ovf_ev = 0;
        unf_ev = 0;
        if (push && pop && stk.size() > 0) begin
            stk[stk.size()-1] = pc;
        end else if (push) begin
            if (stk.size() < DEPTH) begin
                stk.push_back(pc);
            end else begin
                ovf_ev = 1;
`ifdef PC_STACK_WRAP_EN
                void'(stk.pop_front());
                stk.push_back(pc);
`endif
            end
        end else if (pop) begin
            if (stk.size() > 0) void'(stk.pop_back());
            else unf_ev = 1;
        end
        m_ovf = ovf_ev | (m_ovf & !clr);
        m_unf = unf_ev | (m_unf & !clr);
        @(negedge CLK);
        PUSH = 0; POP = 0; CLR_ERR = 0;
    endtask

    initial begin
        // Reset state
        @(negedge CLK);
        #1;
        check_all("reset");
        RST = 0;
        @(negedge CLK);

        // Asynchronous reset mid-cycle with COUNT=3 and UNF set
        step("pre_unf", 0, 1, 0, 2'd1, 10'h000, 10'h000);
        step("pre_p1", 1, 0, 0, 2'd1, 10'h111, 10'h000);
        step("pre_p2", 1, 0, 0, 2'd1, 10'h222, 10'h000);
        step("pre_p3", 1, 0, 0, 2'd1, 10'h333, 10'h000);
        chk("pre_rst.count", 32'(COUNT), 32'd3);
        #2;
        RST = 1;
        #1;
        stk.delete();
        m_ovf = 0;
        m_unf = 0;
        chk("async_rst.count", 32'(COUNT), 32'd0);
        chk("async_rst.empty", 32'(EMPTY), 32'd1);
        chk("async_rst.tos",   32'(TOS),   32'd0);
        chk("async_rst.unf",   32'(UNF),   32'd0);
        check_all("async_rst");
        @(negedge CLK);
        RST = 0;

        // LIFO order
        step("lifo_push0", 1, 0, 0, 2'd1, 10'h010, 10'h000);
        step("lifo_push1", 1, 0, 0, 2'd1, 10'h020, 10'h000);
        step("lifo_push2", 1, 0, 0, 2'd1, 10'h3FF, 10'h000);
        step("lifo_pop0", 0, 1, 0, 2'd1, 10'h000, 10'h000);
        step("lifo_pop1", 0, 1, 0, 2'd1, 10'h000, 10'h000);
        step("lifo_pop2", 0, 1, 0, 2'd1, 10'h000, 10'h000);
        #1;
        chk("lifo_end.empty", 32'(EMPTY), 32'd1);

        // Overflow: DEPTH+1 pushes then DEPTH pops
        for (int i = 1; i <= DEPTH + 1; i++)
            step("ovf_push", 1, 0, 0, 2'd1, 10'(i), 10'h000);
        #1;
        chk("ovf.full", 32'(FULL), 32'd1);
        chk("ovf.flag", 32'(OVF),  32'd1);
`ifdef PC_STACK_WRAP_EN
        chk("ovf.tos",  32'(TOS),  32'(DEPTH + 1));
`else
        chk("ovf.tos",  32'(TOS),  32'(DEPTH));
`endif
        for (int i = 0; i < DEPTH; i++)
            step("ovf_pop", 0, 1, 0, 2'd1, 10'h000, 10'h000);
        #1;
        chk("ovf_drain.unf", 32'(UNF), 32'd0);
        step("ovf_clr", 0, 0, 1, 2'd1, 10'h000, 10'h000);

        // Underflow and clear, including set-wins-over-clear
        step("unf_pop", 0, 1, 0, 2'd1, 10'h000, 10'h000);
        #1;
        chk("unf.flag", 32'(UNF), 32'd1);
        step("unf_clr", 0, 0, 1, 2'd1, 10'h000, 10'h000);
        #1;
        chk("unf_clr.flag", 32'(UNF), 32'd0);
        step("unf_popclr", 0, 1, 1, 2'd1, 10'h000, 10'h000);
        #1;
        chk("unf_popclr.flag", 32'(UNF), 32'd1);
        step("unf_clr2", 0, 0, 1, 2'd1, 10'h000, 10'h000);

        // Simultaneous push+pop at COUNT=2 and COUNT=0
        step("sim_p0", 1, 0, 0, 2'd1, 10'h033, 10'h000);
        step("sim_p1", 1, 0, 0, 2'd1, 10'h055, 10'h000);
        step("sim_rep", 1, 1, 0, 2'd1, 10'h0AA, 10'h000);
        #1;
        chk("sim_rep.count", 32'(COUNT), 32'd2);
        chk("sim_rep.tos",   32'(TOS),   32'h0AA);
        step("sim_d0", 0, 1, 0, 2'd1, 10'h000, 10'h000);
        step("sim_d1", 0, 1, 0, 2'd1, 10'h000, 10'h000);
        step("sim_empty", 1, 1, 0, 2'd1, 10'h0AA, 10'h000);
        #1;
        chk("sim_empty.count", 32'(COUNT), 32'd1);
        chk("sim_empty.tos",   32'(TOS),   32'h0AA);
        chk("sim_empty.unf",   32'(UNF),   32'd0);
        step("sim_d2", 0, 1, 0, 2'd1, 10'h000, 10'h000);

        // Mux sources
        step("mux_push", 1, 0, 0, 2'd1, 10'h045, 10'h000);
        for (int s = 0; s < 4; s++)
            step("mux_sel", 0, 0, 0, 2'(s), 10'h000, 10'h123);
        step("mux_pop", 0, 1, 0, 2'd1, 10'h000, 10'h000);

        // Randomized traffic: push-heavy then pop-heavy phases
        for (int i = 0; i < 600; i++) begin
            int r;
            bit p, q, c;
            r = int'($urandom_range(0, 99));
            if ((i / 100) % 2 == 0) begin
                p = (r < 65);
                q = (r >= 55);
            end else begin
                p = (r < 35);
                q = (r >= 25);
            end
            c = ($urandom_range(0, 15) == 0);
            step("rand", p, q, c, 2'($urandom_range(0, 3)),
                 10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)));
        end

        #1;
        check_all("final");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
